exu_sys_seq: RTL and testbench
==============================

EXU_SYS_SEQ -- requirements
Module: exu_sys_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W (default 12): CSR address width.
REQ-002 The block SHALL have the following ports:
- clk  in  1  core clock; one clock only.
- rst  in  1  reset; synchronous, active-high.
- req_vld  in  1  SYSTEM-opcode instruction offered.
- req_rdy  out  1  sequencer can accept.
- inst  in  32  rv32i_inst_t instruction word.
- flush  in  1  abort current operation.
- gpr_ra1  out  5  GPR read address (rs1).
- gpr_rd1  in  32  GPR read data, combinational from gpr_ra1.
- gpr_wen  out  1  GPR write enable.
- gpr_wa  out  5  GPR write address.
- gpr_wd  out  32  GPR write data.
- csr_addr  out  ADDR_W  CSR address.
- csr_ren  out  1  CSR read strobe.
- csr_rdata  in  32  CSR read data, same cycle as csr_ren.
- csr_wen  out  1  CSR write strobe.
- csr_wdata  out  32  CSR write data.
- done  out  1  one-cycle completion pulse.
- trap_vld  out  1  trap raised with done.
- trap_cause  out  4  0=illegal, 3=ebreak, 11=ecall.
- mret  out  1  MRET retired with done.

Function
REQ-003 The FSM SHALL have states IDLE, EXEC and WB; req_rdy SHALL equal (state==IDLE).
REQ-004 Acceptance SHALL occur on req_vld & req_rdy; inst SHALL be captured into an internal register and the FSM SHALL go IDLE->EXEC.
REQ-005 In EXEC the block SHALL drive gpr_ra1=rs1 and csr_addr=inst[31:20], and SHALL latch the operand and old CSR value; then EXEC->WB.
REQ-006 In WB the block SHALL assert the register writes, done=1 and trap/mret flags; then WB->IDLE. Fixed latency: done 2 cycles after acceptance, throughput one op per 3 cycles.
REQ-007 funct3 decode SHALL be: 001 CSRRW, 010 CSRRS, 011 CSRRC, 101/110/111 immediate forms (operand = zero-extended rs1 field), 000 privileged, 100 illegal.
REQ-008 Privileged (funct3=000, rs1=rd=0) decoding SHALL be: imm 0x000 ECALL (cause 11), 0x001 EBREAK (cause 3), 0x302 MRET, 0x105 WFI (retires as no-op); any other encoding SHALL give trap_vld=1, cause 0.
REQ-009 For CSRRW/CSRRWI with rd=0, csr_ren SHALL stay 0.
REQ-010 For CSRRS/CSRRC and their immediate forms with operand field rs1=0, csr_wen SHALL stay 0.
REQ-011 csr_wdata SHALL be: operand (RW), old|operand (RS), old&~operand (RC).
REQ-012 gpr_wen SHALL be 1 in WB only for CSR ops with rd!=0; gpr_wd SHALL equal the old CSR value.
REQ-013 Trapping or privileged ops SHALL assert neither gpr_wen nor csr_wen.
REQ-014 Outside their active state, all strobes (csr_ren, csr_wen, gpr_wen, done, trap_vld, mret) SHALL be 0 and address/data outputs SHALL be 0.
REQ-015 flush in EXEC or WB SHALL suppress all writes and done that cycle and force state to IDLE next cycle.
REQ-016 flush in IDLE SHALL block acceptance that cycle.

Reset
REQ-017 rst SHALL force state=IDLE and clear the captured instruction and latched values.
REQ-018 During and after reset, req_rdy SHALL be 1 and every other output SHALL be 0.
REQ-019 Reset mid-operation SHALL discard the operation with no writes.

Configuration
REQ-020 Macro EXU_SYS_CSR_EN defined: full CSR behaviour per REQ-005..012.
REQ-021 Macro EXU_SYS_CSR_EN undefined: every CSR funct3 SHALL retire as illegal (trap_vld=1, cause 0); csr_ren and csr_wen SHALL be tied 0; ECALL/EBREAK/MRET/WFI unchanged.

Structure
REQ-022 The shared isa package SHALL hold the SYSTEM opcode, the funct3 encodings, the privileged immediates, the trap cause codes and the FSM state enum.
REQ-023 One sub-module, exu_sys_dec, SHALL be used: combinational decode of inst into op class, operand select and trap cause.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- CSRRW rd=5, rs1=6, csr 0x340, x6=0xA5A5_0000, csr old=0x1234 -> WB: csr_wdata=0xA5A5_0000, gpr wa=5, wd=0x1234, done at cycle+2.
- CSRRS rd=7, rs1=0, csr 0x300 -> csr_ren=1, csr_wen=0, gpr_wd=old value.
- CSRRCI rd=0, zimm=0x3, csr old=0xF -> csr_ren=0; csr_wdata=0xC; gpr_wen=0.
- ECALL -> done with trap_vld=1, cause=11; no writes. MRET -> mret=1.
- flush in EXEC -> no done, no writes; req_rdy=1 next cycle.
- funct3=100, and (without EXU_SYS_CSR_EN) any CSRRW -> trap_vld=1, cause 0.

Source files
------------

// File: rtl/exu_sys_seq_pkg.sv
// Shared ISA definitions for the SYSTEM-opcode sequencer: opcode, funct3,
// privileged immediates, trap causes and FSM/decode enums.
package exu_sys_seq_pkg;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_PRIV   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_ILL    = 3'b100;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [11:0] IMM_ECALL  = 12'h000;
  localparam logic [11:0] IMM_EBREAK = 12'h001;
  localparam logic [11:0] IMM_MRET   = 12'h302;
  localparam logic [11:0] IMM_WFI    = 12'h105;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd0;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;
  typedef enum logic [1:0] {OP_CSR, OP_WFI, OP_MRET, OP_TRAP} op_t;
  typedef enum logic [1:0] {CSR_RW, CSR_RS, CSR_RC} csr_fn_t;

endpackage

// File: rtl/exu_sys_seq_dec.sv
// Combinational SYSTEM instruction decode: op class, CSR function, operand
// select and trap cause. CSR forms decode only when EXU_SYS_CSR_EN is defined.
module exu_sys_dec
  import exu_sys_seq_pkg::*;
(
  input  logic [31:0] inst,
  output op_t         op,
  output csr_fn_t     csr_fn,
  output logic        use_imm,
  output logic [3:0]  cause
);

  logic [2:0] f3;
  logic [4:0] rs1;
  logic [4:0] rd;
  logic [11:0] imm;

  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rd  = inst[11:7];
  assign imm = inst[31:20];

  always_comb begin
    op      = OP_TRAP;
    csr_fn  = CSR_RW;
    use_imm = 1'b0;
    cause   = CAUSE_ILLEGAL;
    if (inst[6:0] == OPC_SYSTEM) begin
      case (f3)
        F3_PRIV: begin
          if (rs1 == 5'd0 && rd == 5'd0) begin
            case (imm)
              IMM_ECALL:  cause = CAUSE_ECALL;
              IMM_EBREAK: cause = CAUSE_EBREAK;
              IMM_MRET:   op    = OP_MRET;
              IMM_WFI:    op    = OP_WFI;
              default:    ;
            endcase
          end
        end
`ifdef EXU_SYS_CSR_EN
        F3_CSRRW, F3_CSRRS, F3_CSRRC, F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: begin
          op      = OP_CSR;
          use_imm = f3[2];
          case (f3[1:0])
            2'b01:   csr_fn = CSR_RW;
            2'b10:   csr_fn = CSR_RS;
            default: csr_fn = CSR_RC;
          endcase
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exu_sys_seq.sv
// SYSTEM-opcode sequencer (IDLE -> EXEC -> WB). Define EXU_SYS_CSR_EN for
// CSR instruction support; otherwise CSR forms retire as illegal.
module exu_sys_seq
  import exu_sys_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [31:0]       inst,
  input  logic              flush,
  output logic [4:0]        gpr_ra1,
  input  logic [31:0]       gpr_rd1,
  output logic              gpr_wen,
  output logic [4:0]        gpr_wa,
  output logic [31:0]       gpr_wd,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_ren,
  input  logic [31:0]       csr_rdata,
  output logic              csr_wen,
  output logic [31:0]       csr_wdata,
  output logic              done,
  output logic              trap_vld,
  output logic [3:0]        trap_cause,
  output logic              mret
);

  state_t      state;
  logic [31:0] inst_q;
  logic [31:0] operand;
  logic [31:0] old_val;

  op_t         op;
  csr_fn_t     csr_fn;
  logic        use_imm;
  logic [3:0]  cause;

  exu_sys_dec u_dec (
    .inst    (inst_q),
    .op      (op),
    .csr_fn  (csr_fn),
    .use_imm (use_imm),
    .cause   (cause)
  );

  logic [4:0] rd;
  logic [4:0] rs1;
  logic       is_csr;
  logic       in_exec;
  logic       in_wb;
  logic       fire;
  logic [31:0] wdata_calc;

  assign rd      = inst_q[11:7];
  assign rs1     = inst_q[19:15];
  assign is_csr  = (op == OP_CSR);
  assign in_exec = (state == ST_EXEC) && !rst;
  assign in_wb   = (state == ST_WB) && !rst;
  assign fire    = in_wb && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      inst_q  <= '0;
      operand <= '0;
      old_val <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_vld && !flush) begin
            inst_q <= inst;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            operand <= use_imm ? {27'd0, rs1} : gpr_rd1;
            old_val <= csr_rdata;
            state   <= ST_WB;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wdata_calc = operand;
    case (csr_fn)
      CSR_RS:  wdata_calc = old_val | operand;
      CSR_RC:  wdata_calc = old_val & ~operand;
      default: wdata_calc = operand;
    endcase
  end

  // Reads with rd=0 are skipped for every CSR form; the bus data is still
  // sampled so RS/RC can compute the write value without a read strobe.
`ifdef EXU_SYS_CSR_EN
  assign csr_ren = in_exec && !flush && is_csr && (rd != 5'd0);
  assign csr_wen = fire && is_csr && !((csr_fn != CSR_RW) && (rs1 == 5'd0));
`else
  assign csr_ren = 1'b0;
  assign csr_wen = 1'b0;
`endif

  assign csr_wdata  = csr_wen ? wdata_calc : '0;
  assign csr_addr   = (in_exec || in_wb) ? ADDR_W'(inst_q[31:20]) : '0;
  assign gpr_ra1    = in_exec ? rs1 : '0;
  assign gpr_wen    = fire && is_csr && (rd != 5'd0);
  assign gpr_wa     = gpr_wen ? rd : '0;
  assign gpr_wd     = gpr_wen ? old_val : '0;
  assign done       = fire;
  assign trap_vld   = fire && (op == OP_TRAP);
  assign trap_cause = trap_vld ? cause : '0;
  assign mret       = fire && (op == OP_MRET);
  assign req_rdy    = rst || (state == ST_IDLE);

endmodule

// File: tb/tb_exu_sys_seq.sv
// Directed table-driven bench for exu_sys_seq, plus reset/flush sequences.
module tb_exu_sys_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] inst;
  logic        flush;
  logic [4:0]  gpr_ra1;
  logic [31:0] gpr_rd1;
  logic        gpr_wen;
  logic [4:0]  gpr_wa;
  logic [31:0] gpr_wd;
  logic [11:0] csr_addr;
  logic        csr_ren;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic        done;
  logic        trap_vld;
  logic [3:0]  trap_cause;
  logic        mret;

  always #5 clk = ~clk;

  exu_sys_seq #(.ADDR_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .inst       (inst),
    .flush      (flush),
    .gpr_ra1    (gpr_ra1),
    .gpr_rd1    (gpr_rd1),
    .gpr_wen    (gpr_wen),
    .gpr_wa     (gpr_wa),
    .gpr_wd     (gpr_wd),
    .csr_addr   (csr_addr),
    .csr_ren    (csr_ren),
    .csr_rdata  (csr_rdata),
    .csr_wen    (csr_wen),
    .csr_wdata  (csr_wdata),
    .done       (done),
    .trap_vld   (trap_vld),
    .trap_cause (trap_cause),
    .mret       (mret)
  );

  // Register file / CSR bus model: only the expected address returns data.
  logic [4:0]  cur_rs1;
  logic [11:0] cur_csr;
  logic [31:0] cur_x;
  logic [31:0] cur_old;
  assign gpr_rd1   = (gpr_ra1 == cur_rs1) ? cur_x : 32'hDEAD_BEEF;
  assign csr_rdata = (csr_addr == cur_csr) ? cur_old : 32'hBAD0_BAD0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] xval;
    logic [31:0] old;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic        gwen;
    logic [4:0]  gwa;
    logic [31:0] gwd;
    logic        trap;
    logic [3:0]  cause;
    logic        mret;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [31:0] mk(logic [11:0] c, logic [4:0] s, logic [2:0] f, logic [4:0] d);
    return {c, s, f, d, 7'b1110011};
  endfunction

  function automatic vec_t csrv(logic [31:0] i, logic [31:0] x, logic [31:0] o, logic ren,
                                logic wen, logic [31:0] wd, logic gwen, logic [31:0] gwd);
    vec_t v;
    v.inst = i; v.xval = x; v.old = o;
`ifdef EXU_SYS_CSR_EN
    v.ren = ren; v.wen = wen; v.wdata = wen ? wd : 32'd0;
    v.gwen = gwen; v.gwa = gwen ? i[11:7] : 5'd0; v.gwd = gwen ? gwd : 32'd0;
    v.trap = 1'b0; v.cause = 4'd0;
`else
    v.ren = 1'b0; v.wen = 1'b0; v.wdata = 32'd0;
    v.gwen = 1'b0; v.gwa = 5'd0; v.gwd = 32'd0;
    v.trap = 1'b1; v.cause = 4'd0;
    if (ren || wen || gwen || wd != 0 || gwd != 0) v.mret = 1'b0;
`endif
    v.mret = 1'b0;
    return v;
  endfunction

  function automatic vec_t sysv(logic [31:0] i, logic trap, logic [3:0] cause, logic m);
    vec_t v;
    v.inst = i; v.xval = 32'h0; v.old = 32'h0;
    v.ren = 1'b0; v.wen = 1'b0; v.wdata = 32'd0;
    v.gwen = 1'b0; v.gwa = 5'd0; v.gwd = 32'd0;
    v.trap = trap; v.cause = cause; v.mret = m;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(logic [31:0] i, logic [31:0] x, logic [31:0] o);
    cur_rs1 = i[19:15]; cur_csr = i[31:20]; cur_x = x; cur_old = o;
  endtask

  // Offer an instruction; returns just after the acceptance edge.
  task automatic accept(logic [31:0] i);
    @(posedge clk); #1;
    req_vld = 1'b1; inst = i;
    @(posedge clk); #1;
    req_vld = 1'b0; inst = '0;
  endtask

  task automatic run_vec(int k);
    vec_t v;
    v = vt[k];
    set_bus(v.inst, v.xval, v.old);
    accept(v.inst);
    @(negedge clk);
    chk($sformatf("v%0d_exec_rdy", k), {31'd0, req_rdy}, 32'd0);
    chk($sformatf("v%0d_ra1", k), {27'd0, gpr_ra1}, {27'd0, v.inst[19:15]});
    chk($sformatf("v%0d_csr_addr", k), {20'd0, csr_addr}, {20'd0, v.inst[31:20]});
    chk($sformatf("v%0d_csr_ren", k), {31'd0, csr_ren}, {31'd0, v.ren});
    chk($sformatf("v%0d_exec_done", k), {31'd0, done}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_done", k), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_csr_wen", k), {31'd0, csr_wen}, {31'd0, v.wen});
    chk($sformatf("v%0d_csr_wdata", k), csr_wdata, v.wdata);
    chk($sformatf("v%0d_gpr_wen", k), {31'd0, gpr_wen}, {31'd0, v.gwen});
    chk($sformatf("v%0d_gpr_wa", k), {27'd0, gpr_wa}, {27'd0, v.gwa});
    chk($sformatf("v%0d_gpr_wd", k), gpr_wd, v.gwd);
    chk($sformatf("v%0d_trap", k), {31'd0, trap_vld}, {31'd0, v.trap});
    chk($sformatf("v%0d_cause", k), {28'd0, trap_cause}, {28'd0, v.cause});
    chk($sformatf("v%0d_mret", k), {31'd0, mret}, {31'd0, v.mret});
    @(negedge clk);
    chk($sformatf("v%0d_idle_rdy", k), {31'd0, req_rdy}, 32'd1);
    chk($sformatf("v%0d_idle_done", k), {31'd0, done}, 32'd0);
  endtask

  task automatic chk_quiet(string name);
    chk({name, "_strobes"},
        {26'd0, csr_ren, csr_wen, gpr_wen, done, trap_vld, mret}, 32'd0);
    chk({name, "_data"}, csr_wdata | gpr_wd, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; inst = '0; flush = 1'b0;
    set_bus(32'h0, 32'h0, 32'h0);

    vt[0]  = csrv(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hA5A5_0000, 32'h1234, 1, 1, 32'hA5A5_0000, 1, 32'h1234);
    vt[1]  = csrv(mk(12'h300, 5'd0, 3'b010, 5'd7), 32'h0, 32'h1888, 1, 0, 32'h0, 1, 32'h1888);
    vt[2]  = csrv(mk(12'h305, 5'd3, 3'b111, 5'd0), 32'h0, 32'hF, 0, 1, 32'hC, 0, 32'h0);
    vt[3]  = csrv(mk(12'h341, 5'd2, 3'b010, 5'd1), 32'h00F0, 32'h0F00, 1, 1, 32'h0FF0, 1, 32'h0F00);
    vt[4]  = csrv(mk(12'h342, 5'd4, 3'b011, 5'd3), 32'hFF, 32'h1234, 1, 1, 32'h1200, 1, 32'h1234);
    vt[5]  = csrv(mk(12'h343, 5'd8, 3'b001, 5'd0), 32'h55, 32'h77, 0, 1, 32'h55, 0, 32'h0);
    vt[6]  = csrv(mk(12'h344, 5'h1F, 3'b101, 5'd9), 32'h0, 32'h100, 1, 1, 32'h1F, 1, 32'h100);
    vt[7]  = csrv(mk(12'h345, 5'd0, 3'b110, 5'd10), 32'h0, 32'hAB, 1, 0, 32'h0, 1, 32'hAB);
    vt[8]  = sysv(32'h0000_0073, 1, 4'd11, 0);
    vt[9]  = sysv(32'h0010_0073, 1, 4'd3, 0);
    vt[10] = sysv(32'h3020_0073, 0, 4'd0, 1);
    vt[11] = sysv(32'h1050_0073, 0, 4'd0, 0);
    vt[12] = sysv(mk(12'h340, 5'd6, 3'b100, 5'd5), 1, 4'd0, 0);
    vt[13] = sysv(32'h0000_00F3, 1, 4'd0, 0);
    vt[14] = sysv(32'h7FF0_0073, 1, 4'd0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {31'd0, req_rdy}, 32'd1);
    chk_quiet("rst");
    chk("rst_addr", {15'd0, gpr_ra1, csr_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, req_rdy}, 32'd1);
    chk_quiet("post_rst");

    for (int i = 0; i < NV; i++) run_vec(i);

    // Flush in EXEC: operation dropped, ready next cycle
    set_bus(vt[0].inst, vt[0].xval, vt[0].old);
    accept(vt[0].inst);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("fex_rdy", {31'd0, req_rdy}, 32'd1);
    chk_quiet("fex");
    @(negedge clk);
    chk_quiet("fex2");

    // Flush in WB: no done, no writes
    accept(vt[0].inst);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk_quiet("fwb");
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("fwb_rdy", {31'd0, req_rdy}, 32'd1);

    // Flush in IDLE blocks acceptance
    @(posedge clk); #1 req_vld = 1'b1; inst = vt[8].inst; flush = 1'b1;
    @(posedge clk); #1 req_vld = 1'b0; inst = '0; flush = 1'b0;
    @(negedge clk);
    chk("fidle_rdy", {31'd0, req_rdy}, 32'd1);
    @(negedge clk);
    chk_quiet("fidle");

    // Reset during WB discards the operation
    accept(vt[0].inst);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk_quiet("rwb");
    chk("rwb_rdy", {31'd0, req_rdy}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rwb_after_rdy", {31'd0, req_rdy}, 32'd1);
    chk_quiet("rwb_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
